// File: rtl/memory_dp_ctrl.sv
// Dual-port byte-writable scratch RAM with sequenced clear engine and collision flag.
// Latency: 1 cycle read (registered rdata/rvalid); writes land on the same edge.
// Backpressure: none; port accesses are silently ignored while busy (clear sweep).
module memory_dp_ctrl #(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = 10,
    parameter int          DEPTH          = 1024,
    parameter int          RDW_MODE       = 0,
    parameter int          CLEAR_ON_RESET = 1,
    parameter logic [15:0] KEY            = 16'h0032
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_wen,
    input  logic [ADDR_W-1:0]     a_waddr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic [DATA_W/8-1:0]   a_wbe,
    input  logic                  a_ren,
    input  logic [ADDR_W-1:0]     a_raddr,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_wen,
    input  logic [ADDR_W-1:0]     b_waddr,
    input  logic [DATA_W-1:0]     b_wdata,
    input  logic [DATA_W/8-1:0]   b_wbe,
    input  logic                  b_ren,
    input  logic [ADDR_W-1:0]     b_raddr,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid,
    input  logic                  init_req,
    output logic                  busy,
    output logic                  collision,
    output logic [15:0]           key_access
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_a_rdata, r_b_rdata;
    logic                r_a_rvalid, r_b_rvalid, r_collision;

    logic                w_idle, w_a_we, w_b_we, w_coll;
    logic [DATA_W-1:0]   w_a_wold, w_b_wold, w_a_wword, w_b_wword;
    logic [DATA_W-1:0]   w_a_rold, w_b_rold, w_a_rnew, w_b_rnew;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
    endfunction

    // Apply A's enabled bytes, then B's, so B wins any byte both ports enable.
    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_word,
        input logic              a_hit,
        input logic [DATA_W-1:0] a_dat,
        input logic [NB-1:0]     a_be,
        input logic              b_hit,
        input logic [DATA_W-1:0] b_dat,
        input logic [NB-1:0]     b_be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (a_hit && a_be[i]) res[8*i +: 8] = a_dat[8*i +: 8];
        end
        for (int i = 0; i < NB; i++) begin
            if (b_hit && b_be[i]) res[8*i +: 8] = b_dat[8*i +: 8];
        end
        return res;
    endfunction

    assign w_idle = (r_state == S_IDLE);
    // Out-of-range writes are dropped here, so they never reach the array or the collision flag.
    assign w_a_we = w_idle && a_wen && in_range(a_waddr);
    assign w_b_we = w_idle && b_wen && in_range(b_waddr);
    assign w_coll = w_a_we && w_b_we && (a_waddr == b_waddr);

    assign w_a_wold  = in_range(a_waddr) ? r_mem[a_waddr] : '0;
    assign w_b_wold  = in_range(b_waddr) ? r_mem[b_waddr] : '0;
    assign w_a_wword = merge(w_a_wold, 1'b1, a_wdata, a_wbe, 1'b0, b_wdata, b_wbe);
    // On a collision the B write carries the fully merged word for the shared address.
    assign w_b_wword = merge(w_b_wold, w_coll, a_wdata, a_wbe, 1'b1, b_wdata, b_wbe);

    assign w_a_rold = in_range(a_raddr) ? r_mem[a_raddr] : '0;
    assign w_b_rold = in_range(b_raddr) ? r_mem[b_raddr] : '0;
    assign w_a_rnew = merge(w_a_rold, w_a_we && (a_waddr == a_raddr), a_wdata, a_wbe,
                            w_b_we && (b_waddr == a_raddr), b_wdata, b_wbe);
    assign w_b_rnew = merge(w_b_rold, w_a_we && (a_waddr == b_raddr), a_wdata, a_wbe,
                            w_b_we && (b_waddr == b_raddr), b_wdata, b_wbe);

    // FSM state and sweep address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RST_STATE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Next-state: start a sweep on request, walk 0..DEPTH-1, then return to idle.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            S_IDLE: begin
                if (init_req) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            S_CLEAR: begin
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    // Array update: the sweep owns the array while clearing; contents are not reset.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
        end else begin
            if (w_a_we && !w_coll) r_mem[a_waddr] <= w_a_wword;
            if (w_b_we)            r_mem[b_waddr] <= w_b_wword;
        end
    end

    // Registered read ports and collision pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_a_rvalid  <= w_idle && a_ren;
            r_b_rvalid  <= w_idle && b_ren;
            r_collision <= w_coll;
            if (w_idle && a_ren) r_a_rdata <= (RDW_MODE != 0) ? w_a_rnew : w_a_rold;
            if (w_idle && b_ren) r_b_rdata <= (RDW_MODE != 0) ? w_b_rnew : w_b_rold;
        end
    end

    assign a_rdata    = r_a_rdata;
    assign b_rdata    = r_b_rdata;
    assign a_rvalid   = r_a_rvalid;
    assign b_rvalid   = r_b_rvalid;
    assign collision  = r_collision;
    assign busy       = (r_state == S_CLEAR);
    assign key_access = KEY;

endmodule
